// File: rtl/preg_freelist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : preg_freelist_pkg
//  Brief    : Shared sizing constants and types for the physical-register
//             free list and its checkpoint store.
//  Revision : 1.0 - initial release
// ============================================================================
package preg_freelist_pkg;

  localparam int NUM_PREGS              = 64;
  localparam int MAX_PREDICT_DEPTH      = 4;
  // Tags run 0..MAX_PREDICT_DEPTH, so one extra code point beyond the slot count.
  localparam int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH + 1);
  localparam int PW                     = $clog2(NUM_PREGS);

  typedef logic [PW-1:0] preg_t;
  typedef logic [PW:0]   ptr_t;

endpackage
`default_nettype wire

// File: rtl/preg_freelist_if.sv
`default_nettype none
// ============================================================================
//  Module   : preg_freelist_if
//  Brief    : Issue/commit/branch-control bundle of the physical-register
//             free list. master = rename/issue control, slave = free list.
//  Revision : 1.0 - initial release
// ============================================================================
interface preg_freelist_if;
  import preg_freelist_pkg::*;

  logic                              alloc_en;
  logic [1:0]                        alloc_req;
  logic                              alloc_ok;
  preg_t                             alloc_preg1;
  preg_t                             alloc_preg2;
  logic                              free_valid1;
  logic                              free_valid2;
  preg_t                             free_preg1;
  preg_t                             free_preg2;
  logic                              save_en;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] save_tag;
  logic                              restore_en;
  logic [MAX_PREDICT_DEPTH_BITS-1:0] restore_tag;
  ptr_t                              free_count;
  logic                              overflow;

  modport master (
    output alloc_en, alloc_req, free_valid1, free_valid2, free_preg1, free_preg2,
           save_en, save_tag, restore_en, restore_tag,
    input  alloc_ok, alloc_preg1, alloc_preg2, free_count, overflow
  );

  modport slave (
    input  alloc_en, alloc_req, free_valid1, free_valid2, free_preg1, free_preg2,
           save_en, save_tag, restore_en, restore_tag,
    output alloc_ok, alloc_preg1, alloc_preg2, free_count, overflow
  );

endinterface
`default_nettype wire

// File: rtl/freelist_ckpt.sv
`default_nettype none
// ============================================================================
//  Module   : freelist_ckpt
//  Brief    : Head-pointer checkpoint store, one slot per branch tag.
//             One write port (save), one combinational read port (restore).
//  Revision : 1.0 - initial release
// ============================================================================
module freelist_ckpt #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7,
  parameter int AW    = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_slot [DEPTH];

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      // Capture the head pointer into this slot when its tag is saved.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_slot[i] <= '0;
        end else if (we && (waddr == AW'(i))) begin
          r_slot[i] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = r_slot[raddr];

endmodule
`default_nettype wire

// File: rtl/preg_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : preg_freelist
//  Brief    : Circular free list of physical registers. Up to two
//             allocations and two releases per cycle, plus per-branch head
//             checkpoints for single-cycle shootdown recovery.
//  Revision : 1.0 - initial release
// ============================================================================
module preg_freelist #(
  parameter int NUM_PREGS         = preg_freelist_pkg::NUM_PREGS,
  parameter int MAX_PREDICT_DEPTH = preg_freelist_pkg::MAX_PREDICT_DEPTH
) (
  input  wire logic       clk,
  input  wire logic       reset,
  preg_freelist_if.slave  bus
);

  localparam int PW = $clog2(NUM_PREGS);
  localparam int TW = $clog2(MAX_PREDICT_DEPTH + 1);
  localparam int SW = (MAX_PREDICT_DEPTH > 1) ? $clog2(MAX_PREDICT_DEPTH) : 1;

  // preg 0 never circulates, so the list holds at most NUM_PREGS-1 entries.
  localparam logic [PW:0] c_max_free = (PW+1)'(NUM_PREGS - 1);

  logic [PW-1:0] r_list [NUM_PREGS];
  logic [PW:0]   r_head;
  logic [PW:0]   r_tail;
  logic [PW:0]   r_free_count;
  logic          r_overflow;

  logic          w_alloc_ok;
  logic          w_alloc_fire;
  logic          w_restore_ok;
  logic          w_save_ok;
  logic          w_save;
  logic [SW-1:0] w_save_idx;
  logic [SW-1:0] w_restore_idx;
  logic [PW:0]   w_ckpt_head;
  logic [PW:0]   w_head_next;
  logic [PW:0]   w_tail_next;
  logic [PW:0]   w_used;
  logic [PW:0]   w_room;
  logic [PW:0]   w_need2;
  logic          w_take1;
  logic          w_take2;
  logic          w_acc1;
  logic          w_acc2;
  logic          w_drop;
  logic [PW-1:0] w_head_idx1;
  logic [PW-1:0] w_wr1_idx;
  logic [PW-1:0] w_wr2_idx;

  // ---------------------------------------------------------------- allocate
  assign w_alloc_ok   = (r_free_count >= {{(PW-1){1'b0}}, bus.alloc_req}) && !bus.restore_en;
  assign w_alloc_fire = bus.alloc_en && w_alloc_ok;

  assign w_head_idx1     = r_head[PW-1:0] + PW'(1);
  assign bus.alloc_preg1 = r_list[r_head[PW-1:0]];
  assign bus.alloc_preg2 = r_list[w_head_idx1];
  assign bus.alloc_ok    = w_alloc_ok;
  assign bus.free_count  = r_free_count;
  assign bus.overflow    = r_overflow;

  // ------------------------------------------------------------- checkpoints
  // Tags outside 1..MAX_PREDICT_DEPTH address no slot and are ignored.
  assign w_restore_ok  = (bus.restore_tag != '0) && (bus.restore_tag <= TW'(MAX_PREDICT_DEPTH));
  assign w_save_ok     = (bus.save_tag != '0) && (bus.save_tag <= TW'(MAX_PREDICT_DEPTH));
  assign w_save        = bus.save_en && w_save_ok && !bus.restore_en;
  assign w_save_idx    = SW'(bus.save_tag - TW'(1));
  assign w_restore_idx = SW'(bus.restore_tag - TW'(1));

  // The saved value is the post-allocation head, so the checkpoint marks the
  // first register handed out after the branch.
  freelist_ckpt #(
    .DEPTH (MAX_PREDICT_DEPTH),
    .WIDTH (PW + 1),
    .AW    (SW)
  ) u_ckpt (
    .clk   (clk),
    .reset (reset),
    .we    (w_save),
    .waddr (w_save_idx),
    .wdata (w_head_next),
    .raddr (w_restore_idx),
    .rdata (w_ckpt_head)
  );

  // Next head: a restore overrides any allocation in the same cycle.
  always_comb begin
    w_head_next = r_head;
    if (bus.restore_en) begin
      if (w_restore_ok) begin
        w_head_next = w_ckpt_head;
      end
    end else if (w_alloc_fire) begin
      w_head_next = r_head + {{(PW-1){1'b0}}, bus.alloc_req};
    end
  end

  // -------------------------------------------------------------------- free
  // Room is measured against the post-allocation head so a same-cycle
  // allocation makes space for a same-cycle release.
  assign w_used  = r_tail - w_head_next;
  assign w_room  = c_max_free - w_used;
  assign w_take1 = bus.free_valid1 && (bus.free_preg1 != '0);
  assign w_take2 = bus.free_valid2 && (bus.free_preg2 != '0);
  assign w_acc1  = w_take1 && (w_room != '0);
  assign w_need2 = w_acc1 ? (PW+1)'(2) : (PW+1)'(1);
  assign w_acc2  = w_take2 && (w_room >= w_need2);
  assign w_drop  = (w_take1 && !w_acc1) || (w_take2 && !w_acc2);

  assign w_wr1_idx   = r_tail[PW-1:0];
  assign w_wr2_idx   = r_tail[PW-1:0] + {{(PW-1){1'b0}}, w_acc1};
  assign w_tail_next = r_tail + {{PW{1'b0}}, w_acc1} + {{PW{1'b0}}, w_acc2};

  generate
    for (genvar i = 0; i < NUM_PREGS; i++) begin : g_entry
      // List entry: reset to the identity chain 1..N-1, then refilled by frees.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_list[i] <= (i < NUM_PREGS - 1) ? PW'(i + 1) : '0;
        end else if (w_acc2 && (w_wr2_idx == PW'(i))) begin
          r_list[i] <= bus.free_preg2;
        end else if (w_acc1 && (w_wr1_idx == PW'(i))) begin
          r_list[i] <= bus.free_preg1;
        end
      end
    end
  endgenerate

  // Pointer, count and sticky overflow state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head       <= '0;
      r_tail       <= c_max_free;
      r_free_count <= c_max_free;
      r_overflow   <= 1'b0;
    end else begin
      r_head       <= w_head_next;
      r_tail       <= w_tail_next;
      r_free_count <= w_tail_next - w_head_next;
      r_overflow   <= r_overflow | w_drop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_preg_freelist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_preg_freelist
//  Brief    : Directed self-checking bench for preg_freelist.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_preg_freelist;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  preg_freelist_if bus ();

  preg_freelist dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.alloc_en    = 1'b0;
    bus.alloc_req   = 2'd0;
    bus.free_valid1 = 1'b0;
    bus.free_valid2 = 1'b0;
    bus.free_preg1  = '0;
    bus.free_preg2  = '0;
    bus.save_en     = 1'b0;
    bus.save_tag    = '0;
    bus.restore_en  = 1'b0;
    bus.restore_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    tick();
    n_vec++; if (bus.free_count !== 7'd63) begin n_err++; $display("FAIL rst_count: got %0d expected 63", bus.free_count); end
    n_vec++; if (bus.alloc_preg1 !== 6'd1) begin n_err++; $display("FAIL rst_preg1: got %0d expected 1", bus.alloc_preg1); end
    n_vec++; if (bus.alloc_preg2 !== 6'd2) begin n_err++; $display("FAIL rst_preg2: got %0d expected 2", bus.alloc_preg2); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %0b expected 0", bus.overflow); end
    reset = 1'b1;
    tick();
    bus.alloc_req = 2'd2;
    #1;
    n_vec++; if (bus.alloc_ok !== 1'b1) begin n_err++; $display("FAIL rst_alloc_ok: got %0b expected 1", bus.alloc_ok); end
  endtask

  task automatic test_alloc_pair();
    bus.alloc_en  = 1'b1;
    bus.alloc_req = 2'd2;
    #1;
    n_vec++; if (bus.alloc_preg1 !== 6'd1 || bus.alloc_preg2 !== 6'd2) begin n_err++; $display("FAIL pair_pregs: got %0d/%0d expected 1/2", bus.alloc_preg1, bus.alloc_preg2); end
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd61) begin n_err++; $display("FAIL pair_count: got %0d expected 61", bus.free_count); end
    n_vec++; if (bus.alloc_preg1 !== 6'd3) begin n_err++; $display("FAIL pair_next: got %0d expected 3", bus.alloc_preg1); end
  endtask

  task automatic test_exhaust();
    bus.alloc_en  = 1'b1;
    bus.alloc_req = 2'd2;
    repeat (30) tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd1) begin n_err++; $display("FAIL exh_count1: got %0d expected 1", bus.free_count); end
    n_vec++; if (bus.alloc_ok !== 1'b0) begin n_err++; $display("FAIL exh_req2_ok: got %0b expected 0", bus.alloc_ok); end
    bus.alloc_req = 2'd1;
    #1;
    n_vec++; if (bus.alloc_ok !== 1'b1) begin n_err++; $display("FAIL exh_req1_ok: got %0b expected 1", bus.alloc_ok); end
    n_vec++; if (bus.alloc_preg1 !== 6'd63) begin n_err++; $display("FAIL exh_last_preg: got %0d expected 63", bus.alloc_preg1); end
    bus.alloc_en = 1'b1;
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd0) begin n_err++; $display("FAIL exh_empty: got %0d expected 0", bus.free_count); end
    n_vec++; if (bus.alloc_ok !== 1'b0) begin n_err++; $display("FAIL exh_empty_ok: got %0b expected 0", bus.alloc_ok); end
    bus.alloc_req = 2'd0;
    #1;
    n_vec++; if (bus.alloc_ok !== 1'b1) begin n_err++; $display("FAIL exh_req0_ok: got %0b expected 1", bus.alloc_ok); end
    bus.alloc_en  = 1'b1;
    bus.alloc_req = 2'd2;
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd0) begin n_err++; $display("FAIL exh_hold: got %0d expected 0", bus.free_count); end
  endtask

  task automatic test_free_empty();
    bus.alloc_req   = 2'd1;
    bus.free_valid2 = 1'b1;
    bus.free_preg2  = 6'd5;
    #1;
    n_vec++; if (bus.alloc_ok !== 1'b0) begin n_err++; $display("FAIL nobypass_ok: got %0b expected 0", bus.alloc_ok); end
    n_vec++; if (bus.alloc_preg1 !== 6'd0) begin n_err++; $display("FAIL nobypass_preg: got %0d expected 0", bus.alloc_preg1); end
    tick();
    bus.free_valid2 = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd1) begin n_err++; $display("FAIL fe_count: got %0d expected 1", bus.free_count); end
    n_vec++; if (bus.alloc_preg1 !== 6'd5 || bus.alloc_ok !== 1'b1) begin n_err++; $display("FAIL fe_preg: got %0d ok %0b expected 5 ok 1", bus.alloc_preg1, bus.alloc_ok); end
    bus.alloc_en = 1'b1;
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd0) begin n_err++; $display("FAIL fe_drain: got %0d expected 0", bus.free_count); end
  endtask

  task automatic test_free_zero();
    bus.free_valid1 = 1'b1;
    bus.free_preg1  = 6'd0;
    bus.free_valid2 = 1'b1;
    bus.free_preg2  = 6'd9;
    tick();
    idle();
    #1;
    n_vec++; if (bus.free_count !== 7'd1) begin n_err++; $display("FAIL fz_count: got %0d expected 1", bus.free_count); end
    n_vec++; if (bus.alloc_preg1 !== 6'd9) begin n_err++; $display("FAIL fz_preg: got %0d expected 9", bus.alloc_preg1); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fz_overflow: got %0b expected 0", bus.overflow); end
  endtask

  task automatic test_checkpoint();
    for (int k = 0; k < 6; k++) begin
      bus.free_valid1 = 1'b1;
      bus.free_preg1  = 6'(20 + 2 * k);
      bus.free_valid2 = 1'b1;
      bus.free_preg2  = 6'(21 + 2 * k);
      tick();
    end
    idle();
    #1;
    n_vec++; if (bus.free_count !== 7'd13) begin n_err++; $display("FAIL ck_fill: got %0d expected 13", bus.free_count); end
    // Save tag 1 while allocating 9 and 20: checkpoint lands on the entry holding 21.
    bus.alloc_en  = 1'b1;
    bus.alloc_req = 2'd2;
    bus.save_en   = 1'b1;
    bus.save_tag  = 3'd1;
    #1;
    n_vec++; if (bus.alloc_preg1 !== 6'd9 || bus.alloc_preg2 !== 6'd20) begin n_err++; $display("FAIL ck_save_pregs: got %0d/%0d expected 9/20", bus.alloc_preg1, bus.alloc_preg2); end
    tick();
    bus.save_en = 1'b0;
    tick();
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 7'd7 || bus.alloc_preg1 !== 6'd25) begin n_err++; $display("FAIL ck_spec: got count %0d preg %0d expected 7/25", bus.free_count, bus.alloc_preg1); end
    // Restore tag 1 with allocation requested, a free, and a competing save.
    bus.alloc_en    = 1'b1;
    bus.alloc_req   = 2'd2;
    bus.restore_en  = 1'b1;
    bus.restore_tag = 3'd1;
    bus.free_valid1 = 1'b1;
    bus.free_preg1  = 6'd7;
    bus.save_en     = 1'b1;
    bus.save_tag    = 3'd2;
    #1;
    n_vec++; if (bus.alloc_ok !== 1'b0) begin n_err++; $display("FAIL ck_restore_ok: got %0b expected 0", bus.alloc_ok); end
    tick();
    idle();
    #1;
    n_vec++; if (bus.free_count !== 7'd12) begin n_err++; $display("FAIL ck_restore_count: got %0d expected 12", bus.free_count); end
    n_vec++; if (bus.alloc_preg1 !== 6'd21 || bus.alloc_preg2 !== 6'd22) begin n_err++; $display("FAIL ck_restore_pregs: got %0d/%0d expected 21/22", bus.alloc_preg1, bus.alloc_preg2); end
    // Tag 2 was never saved (save lost to restore), so it still points at 0.
    bus.restore_en  = 1'b1;
    bus.restore_tag = 3'd2;
    tick();
    idle();
    #1;
    n_vec++; if (bus.alloc_preg1 !== 6'd9 || bus.free_count !== 7'd78) begin n_err++; $display("FAIL ck_save_ignored: got preg %0d count %0d expected 9/78", bus.alloc_preg1, bus.free_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.alloc_en    = 1'b1;
    bus.alloc_req   = 2'd2;
    bus.free_valid1 = 1'b1;
    bus.free_preg1  = 6'd50;
    tick();
    idle();
    #1;
    n_vec++; if (bus.free_count !== 7'd62 || bus.overflow !== 1'b0) begin n_err++; $display("FAIL b2b_count: got %0d ovf %0b expected 62/0", bus.free_count, bus.overflow); end
    bus.alloc_en  = 1'b1;
    bus.alloc_req = 2'd2;
    repeat (30) tick();
    bus.alloc_req = 2'd1;
    tick();
    idle();
    #1;
    n_vec++; if (bus.alloc_preg1 !== 6'd50 || bus.free_count !== 7'd1) begin n_err++; $display("FAIL b2b_wrap: got preg %0d count %0d expected 50/1", bus.alloc_preg1, bus.free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.free_valid1 = 1'b1;
    bus.free_preg1  = 6'd40;
    tick();
    idle();
    #1;
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b expected 1", bus.overflow); end
    n_vec++; if (bus.free_count !== 7'd63 || bus.alloc_preg1 !== 6'd1) begin n_err++; $display("FAIL ovf_dropped: got count %0d preg %0d expected 63/1", bus.free_count, bus.alloc_preg1); end
    repeat (3) tick();
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b expected 1", bus.overflow); end
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_async_clr: got %0b expected 0", bus.overflow); end
    reset = 1'b1;
    tick();
    // One allocation frees one slot: first release fits, second is dropped.
    bus.alloc_en    = 1'b1;
    bus.alloc_req   = 2'd1;
    bus.free_valid1 = 1'b1;
    bus.free_preg1  = 6'd33;
    bus.free_valid2 = 1'b1;
    bus.free_preg2  = 6'd44;
    tick();
    idle();
    #1;
    n_vec++; if (bus.free_count !== 7'd63 || bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_partial: got count %0d ovf %0b expected 63/1", bus.free_count, bus.overflow); end
    n_vec++; if (bus.alloc_preg1 !== 6'd2) begin n_err++; $display("FAIL ovf_partial_head: got %0d expected 2", bus.alloc_preg1); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_alloc_pair();
    test_exhaust();
    test_free_empty();
    test_free_zero();
    test_checkpoint();
    test_back_to_back();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free list for the rename/issue stage. Hands out up to two free physical registers per cycle to the issue stage (`preg1`/`preg2`), takes back up to two released registers per cycle from commit, and holds one head-pointer checkpoint per branch tag so a branch shootdown can return every register allocated after that branch in one cycle.

## Interface
Parameters:
- `NUM_PREGS`, 64: physical registers; power of two, shared package constant.
- `MAX_PREDICT_DEPTH`, 4: checkpoint slots; branch tags run 1..MAX_PREDICT_DEPTH (tag 0 = unspeculated).
- `PW`, `$clog2(NUM_PREGS)`: preg index width (derived).
- `TW`, `MAX_PREDICT_DEPTH_BITS`: branch tag width (derived).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `alloc_en`  in  1  issue stage advancing this cycle.
- `alloc_req`  in  2  registers wanted, 0..2 (`num_execute`).
- `alloc_ok`  out  1  `free_count >= alloc_req && !restore_en`.
- `alloc_preg1`, `alloc_preg2`  out  PW  head and head+1 entries; combinational.
- `free_valid1`, `free_valid2`  in  1  commit releases a register.
- `free_preg1`, `free_preg2`  in  PW  released register indices.
- `save_en`  in  1  take a checkpoint.
- `save_tag`  in  TW  checkpoint slot.
- `restore_en`  in  1  branch shootdown.
- `restore_tag`  in  TW  slot to roll back to.
- `free_count`  out  PW+1  registered count of free entries.
- `overflow`  out  1  sticky error flag.

## Operation
- Storage: circular array `list[NUM_PREGS]` of PW-bit entries. `head` and `tail` are PW+1 bits; the extra bit is the wrap bit. `free_count = tail - head`.
- Reset (async, `reset`=0):
  - `list[i] = i+1` for i < NUM_PREGS-1.
  - `head = 0`, `tail = NUM_PREGS-1`, `free_count = NUM_PREGS-1`.
  - `overflow = 0`; all checkpoints = 0; `alloc_preg1 = 1`, `alloc_preg2 = 2`.
  - preg 0 is the reset mapping of every architectural register and never enters the list.
- Allocate: when `alloc_en && alloc_ok`, `head += alloc_req`. When `alloc_en && !alloc_ok`, nothing changes; the issue stage must hold.
- Free:
  - Each valid `free_preg` is written at `tail`, packed in order (slot 1 first, then slot 2). `tail` advances by the number written.
  - A free of preg 0 is dropped and does not advance `tail`.
  - Double frees are not detected.
- Overflow: a free that would push `free_count` above NUM_PREGS-1 is dropped and sets `overflow`, which stays set until reset.
- Checkpoint: `save_en` writes `ckpt[save_tag-1]`. The value stored is the head after this cycle's allocation. `save_tag` 0 is ignored.
- Restore: `restore_en` sets `head = ckpt[restore_tag-1]`. Allocation is suppressed that cycle. Frees in the same cycle still apply to `tail`.
- Restore and save in the same cycle: the restore wins and the save is ignored.
- No bypass: a register freed in cycle N is allocatable from cycle N+1.

## Timing
- `alloc_preg1`/`alloc_preg2` are valid in the same cycle from the current `head`. Consumers sample them at the posedge on which `alloc_en` is high.
- `head`, `tail`, `free_count` and checkpoints update on the posedge. `alloc_ok` reflects the new count one cycle after any change.
- Wrap: pointer arithmetic is modulo 2·NUM_PREGS; list indexing uses the low PW bits. `head+1` wraps at NUM_PREGS.
- Empty (`free_count` = 0): `alloc_ok` = 0 for any `alloc_req` > 0. `alloc_req` = 0 always gives `alloc_ok` = 1 unless restoring.
- Reset mid-operation takes effect immediately, regardless of `clk`.

## Structure
- Shared package holds `NUM_PREGS`, `MAX_PREDICT_DEPTH`, `MAX_PREDICT_DEPTH_BITS` and a `preg_t` typedef (PW-bit logic).
- One sub-module, `freelist_ckpt`: a MAX_PREDICT_DEPTH × (PW+1) register file with one write port (save) and one read port (restore), async-reset to 0.
- Everything else (pointer logic and the list array) stays in `preg_freelist`.

## Test plan
- Reset, then `alloc_req`=2 with `alloc_en` → `alloc_preg1`=1, `alloc_preg2`=2; next cycle `free_count`=61, `alloc_preg1`=3.
- Allocate 2 per cycle for 31 cycles, then request 2 → `alloc_ok`=0 with `free_count`=1; `alloc_req`=1 → `alloc_ok`=1 and `alloc_preg1`=63.
- At `free_count`=0, assert `free_valid2` alone with preg 5 → `list[tail]`=5, `free_count`=1; next allocation returns 5 only from the following cycle.
- Save tag 1 at head=10, allocate 6, then restore tag 1 while `alloc_en`=1 and freeing preg 7 → head=10, no allocation that cycle, `free_count` +1, `alloc_preg1` equals the preg previously at index 10.
- Free preg 0 together with preg 9 → only 9 is written and `tail` advances by 1.
- At reset state (count 63), free preg 40 → dropped, `overflow`=1 and stays high until reset is asserted.
